tone_sequencer: RTL
===================

# tone_sequencer

Parametrised note player for the game's audio path: accepts a queue of (note, duration) entries over a valid/ready handshake and plays each one as a square wave. Each note lasts a fixed number of millisecond ticks, with optional silent articulation gaps between notes. It sits between the game-state controller, which queues win/drop/error jingles, and the buzzer pad. The controller pushes a whole jingle and leaves the sequencing to this block.

## Interface
- `CLK_FREQ`, 25_000_000, system clock frequency in Hz; all note thresholds derive from it.
- `TICK_HZ`, 1000, duration tick rate (1 ms).
- `DUR_BITS`, 8, width of a note duration in ticks.
- `GAP_TICKS`, 10, silent ticks inserted after each note; 0 disables the gap.
- `DEPTH`, 4, entry queue depth; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  entry offered.
- `in_ready`  out  1  queue not full; entry accepted when `in_valid && in_ready`.
- `in_note`  in  4  note code; 0 = rest.
- `in_dur`  in  DUR_BITS  duration in ticks.
- `enable`  in  1  0 = pause: all counters hold, output forced low.
- `tone_out`  out  1  square wave to buzzer.
- `busy`  out  1  playing, in a gap, or queue non-empty.
- `done`  out  1  one-cycle pulse when the last queued entry (including its gap) finishes and the queue is empty.

## Operation
- **Note codes:** 1=C6 1047 Hz, 2=D6 1175, 3=E6 1319, 4=F6 1397, 5=G6 1568, 6=B6 1976, 7=C7 2093, 8=G5 784, 9=F4 349, 10=B3 247. Codes 0 and 11–15 are rests.
- **Half-period threshold:** `T = CLK_FREQ/(2*f) - 1`, truncating integer division. Divider width is derived as `$clog2` of T(B3)+1, so no threshold truncates.
- **Tick length:** `TICK_CLKS = CLK_FREQ/TICK_HZ`.
- **FSM states:** IDLE, PLAY, GAP.
  - IDLE: if the queue is non-empty, pop the head, latch note/T/dur, clear all counters, and go to PLAY.
  - PLAY: the divider counts up. When `div >= T`, set `div` to 0 and toggle `tone_out`. For rests, `tone_out` stays 0 and the divider holds at 0. The tick prescaler counts 0..TICK_CLKS-1; each wrap decrements the remaining duration. When the remaining duration reaches 0, force `tone_out` to 0 and go to GAP, or to IDLE if `GAP_TICKS`=0.
  - GAP: `tone_out` is 0. Count `GAP_TICKS` ticks, then go to IDLE.
- **Transition at end of an entry:** if the queue is non-empty when PLAY/GAP ends, pop directly and re-enter PLAY in the same transition, with no IDLE cycle.
- **`dur` = 0:** the entry is consumed, PLAY lasts 1 cycle with `tone_out` 0, then the gap applies.
- **`enable` = 0:** FSM, queue pointers, and all counters hold. `tone_out` is 0; the toggle phase is preserved internally and restored when `enable` returns. Queue pushes are still accepted.
- **Full queue:** `in_ready` = 0 and no push occurs. A pop and a push in the same cycle on a non-full queue are both honoured.
- **Reset:** the queue is flushed, the FSM goes to IDLE, and all counters clear. A reset mid-note silences the output on the next edge.

## Timing
- **Reset values:** `tone_out`=0, `busy`=0, `done`=0, `in_ready`=1.
- **Push to first edge:** a push accepted at edge n into an empty, idle block puts PLAY active from edge n+2. The first `tone_out` rise occurs at edge n+3+T.
- **Note length:** PLAY lasts exactly `dur*TICK_CLKS` enabled cycles. GAP lasts exactly `GAP_TICKS*TICK_CLKS` enabled cycles.
- **`done`:** asserted the cycle the FSM enters IDLE with the queue empty. `busy` drops in the same cycle.
- **`in_ready`:** registered from queue occupancy and updates the cycle after a push or pop.

## Structure
- **Package `tone_pkg`:** note-code constants, note frequencies, and a function `half_period(clk_freq, f)`.
- **Sub-module `note_fifo`:** a DEPTH×(4+DUR_BITS) synchronous FIFO with full/empty flags.
- **`tone_sequencer` top:** contains the FSM, divider, tick prescaler, and the threshold lookup (a case on the latched note code).

## Test plan
Use `CLK_FREQ`=1_000_000, `TICK_HZ`=1000, `GAP_TICKS`=2 unless noted.
1. Push (1, 3). `tone_out` toggles every 477 cycles (T=476), first rise at push+479 cycles. PLAY lasts 3000 cycles, then a 2000-cycle gap, then `done` pulses once.
2. Push (0, 2) then (10, 1). 4000 cycles low (2000 rest + 2000 gap), then B3 with T=2023 for 1000 cycles, then the gap, then `done`.
3. Hold `in_valid` with 6 entries while the first is playing. `in_ready` drops once 4 entries are queued; the 5th is accepted only after a pop. All accepted entries play in order.
4. Drop `enable` for 500 cycles mid-note. `tone_out` stays 0 and the note's end is delayed by exactly 500 cycles. Phase resumes with no counter reset.
5. Assert `rst` mid-note with 2 entries queued. Next cycle: `tone_out`=0, `busy`=0, `in_ready`=1, and no further tone occurs.
6. Push (3, 0) with `GAP_TICKS`=0. The entry is consumed, `tone_out` never rises, and `done` pulses 3 cycles after the push.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: note codes, note frequencies and the half-period helper shared by tone_sequencer.
package tone_pkg;
    localparam logic [3:0] NOTE_C6 = 4'd1;
    localparam logic [3:0] NOTE_D6 = 4'd2;
    localparam logic [3:0] NOTE_E6 = 4'd3;
    localparam logic [3:0] NOTE_F6 = 4'd4;
    localparam logic [3:0] NOTE_G6 = 4'd5;
    localparam logic [3:0] NOTE_B6 = 4'd6;
    localparam logic [3:0] NOTE_C7 = 4'd7;
    localparam logic [3:0] NOTE_G5 = 4'd8;
    localparam logic [3:0] NOTE_F4 = 4'd9;
    localparam logic [3:0] NOTE_B3 = 4'd10;
    localparam int F_C6 = 1047;
    localparam int F_D6 = 1175;
    localparam int F_E6 = 1319;
    localparam int F_F6 = 1397;
    localparam int F_G6 = 1568;
    localparam int F_B6 = 1976;
    localparam int F_C7 = 2093;
    localparam int F_G5 = 784;
    localparam int F_F4 = 349;
    localparam int F_B3 = 247;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;
    function automatic int half_period(input int clk_freq, input int f);
        return clk_freq / (2 * f) - 1;
    endfunction
endpackage

// File: rtl/note_fifo.sv
// note_fifo: synchronous FIFO with full/empty flags; an entry becomes poppable
// (avail) one cycle after the edge that wrote it.
module note_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         avail
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0] cnt_q, cnt_d;
    logic wr_q, wr_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = din;
        wp_d = wp_q + AW'(push);
        rp_d = rp_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        wr_d = push;
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
            wr_q <= 1'b0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
            wr_q <= wr_d;
        end
    end
    assign dout = mem_q[rp_q];
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    // the entry written on the previous edge is still in flight
    assign avail = cnt_q > (AW+1)'(wr_q);
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: queues (note, duration) entries and plays each as a square
// wave for dur ticks, followed by an optional silent gap.
module tone_sequencer import tone_pkg::*; #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int DUR_BITS  = 8,
    parameter int GAP_TICKS = 10,
    parameter int DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_note,
    input  logic [DUR_BITS-1:0] in_dur,
    input  logic                enable,
    output logic                tone_out,
    output logic                busy,
    output logic                done
);
    localparam int TICK_CLKS = CLK_FREQ / TICK_HZ;
    localparam int DIV_W = $clog2(half_period(CLK_FREQ, F_B3) + 1);
    localparam int PW = $clog2(TICK_CLKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int RW = DUR_BITS > GW ? DUR_BITS : GW;
    localparam int EW = 4 + DUR_BITS;
    localparam logic [DIV_W-1:0] T_C6 = DIV_W'(half_period(CLK_FREQ, F_C6));
    localparam logic [DIV_W-1:0] T_D6 = DIV_W'(half_period(CLK_FREQ, F_D6));
    localparam logic [DIV_W-1:0] T_E6 = DIV_W'(half_period(CLK_FREQ, F_E6));
    localparam logic [DIV_W-1:0] T_F6 = DIV_W'(half_period(CLK_FREQ, F_F6));
    localparam logic [DIV_W-1:0] T_G6 = DIV_W'(half_period(CLK_FREQ, F_G6));
    localparam logic [DIV_W-1:0] T_B6 = DIV_W'(half_period(CLK_FREQ, F_B6));
    localparam logic [DIV_W-1:0] T_C7 = DIV_W'(half_period(CLK_FREQ, F_C7));
    localparam logic [DIV_W-1:0] T_G5 = DIV_W'(half_period(CLK_FREQ, F_G5));
    localparam logic [DIV_W-1:0] T_F4 = DIV_W'(half_period(CLK_FREQ, F_F4));
    localparam logic [DIV_W-1:0] T_B3 = DIV_W'(half_period(CLK_FREQ, F_B3));

    state_t state_q, state_d;
    logic [3:0] note_q, note_d;
    logic [DIV_W-1:0] div_q, div_d, thr;
    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] rem_q, rem_d;
    logic tone_q, tone_d, done_q, done_d;
    logic [EW-1:0] head;
    logic full, empty, avail, push, pop, rest, tick, last, play_end, fin;

    assign push = in_valid && !full;
    note_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({in_note, in_dur}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .avail (avail)
    );

    always_comb begin
        thr = '0;
        rest = 1'b0;
        case (note_q)
            NOTE_C6: thr = T_C6;
            NOTE_D6: thr = T_D6;
            NOTE_E6: thr = T_E6;
            NOTE_F6: thr = T_F6;
            NOTE_G6: thr = T_G6;
            NOTE_B6: thr = T_B6;
            NOTE_C7: thr = T_C7;
            NOTE_G5: thr = T_G5;
            NOTE_F4: thr = T_F4;
            NOTE_B3: thr = T_B3;
            default: rest = 1'b1;
        endcase
    end

    // rem_q == 0 in PLAY only happens for a zero-duration entry
    assign tick = presc_q == PW'(TICK_CLKS - 1);
    assign last = tick && rem_q == RW'(1);
    assign play_end = state_q == S_PLAY && (rem_q == '0 || last);
    assign fin = (play_end && GAP_TICKS == 0) || (state_q == S_GAP && last);
    assign pop = enable && (state_q == S_IDLE || fin) && avail;
    assign done_d = enable && fin && !avail && empty && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            note_q <= '0;
            div_q <= '0;
            presc_q <= '0;
            rem_q <= '0;
            tone_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            note_q <= note_d;
            div_q <= div_d;
            presc_q <= presc_d;
            rem_q <= rem_d;
            tone_q <= tone_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        note_d = note_q;
        div_d = div_q;
        presc_d = presc_q;
        rem_d = rem_q;
        tone_d = tone_q;
        if (enable && state_q != S_IDLE) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            rem_d = tick ? rem_q - RW'(1) : rem_q;
        end
        if (enable && state_q == S_PLAY) begin
            div_d = (rest || div_q >= thr) ? '0 : div_q + DIV_W'(1);
            tone_d = !rest && (div_q >= thr ? !tone_q : tone_q);
        end
        if (enable && play_end && !fin) begin
            state_d = S_GAP;
            rem_d = RW'(GAP_TICKS);
            presc_d = '0;
            div_d = '0;
            tone_d = 1'b0;
        end
        if (enable && fin) begin
            state_d = S_IDLE;
            rem_d = '0;
            presc_d = '0;
            div_d = '0;
            tone_d = 1'b0;
        end
        if (pop) begin
            state_d = S_PLAY;
            note_d = head[EW-1 -: 4];
            rem_d = RW'(head[DUR_BITS-1:0]);
            presc_d = '0;
            div_d = '0;
            tone_d = 1'b0;
        end
    end

    always_comb begin
        tone_out = tone_q && enable;
        busy = state_q != S_IDLE || !empty;
        done = done_q;
        in_ready = !full;
    end
endmodule
